// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and its surroundings:
// reset sources in, staggered active-low resets and status out.
interface reset_sequencer_if;
    logic       btn_i;
    logic       sw_rst_req;
    logic       resetn_mem;
    logic       resetn_core;
    logic       busy;
    logic [1:0] rst_cause;

    modport master (
        output btn_i,
        output sw_rst_req,
        input  resetn_mem,
        input  resetn_core,
        input  busy,
        input  rst_cause
    );

    modport slave (
        input  btn_i,
        input  sw_rst_req,
        output resetn_mem,
        output resetn_core,
        output busy,
        output rst_cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staggered reset sequencer: HOLD -> STAGGER -> RUN with debounced button and cause logging.
// Define SWRST_EN to honor sw_rst_req in RUN; otherwise the request is ignored.
module reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STAGGER_CYCLES  = 3
) (
    input  logic              clk,
    input  logic              RESET,
    reset_sequencer_if.slave  bus
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DCNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef SWRST_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STAGGER,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [1:0]          cause_q, cause_d;
    logic                sync1_q, btn_s_q;
    logic                resetn_mem_q, resetn_mem_d;
    logic                resetn_core_q, resetn_core_d;
    logic                busy_q, busy_d;
    logic                btn_ev;
    logic                sw_ev;

    assign sw_ev = bus.sw_rst_req & SW_EN;

    always_comb begin
        dcnt_d = dcnt_q;
        if (!btn_s_q) begin
            dcnt_d = '0;
        end else if (dcnt_q != DCNT_W'(DEBOUNCE_CYCLES)) begin
            dcnt_d = dcnt_q + DCNT_W'(1);
        end
        // Fires only on the step into saturation, so a long press yields one event.
        btn_ev = btn_s_q && (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1));

        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_STAGGER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STAGGER: begin
                if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_ev) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_SW;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase

        // The button restarts the sequence from any state and outranks software.
        if (btn_ev) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            cause_d = CAUSE_BTN;
        end

        resetn_mem_d  = (state_d != ST_HOLD);
        resetn_core_d = (state_d == ST_RUN);
        busy_d        = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync1_q       <= 1'b0;
            btn_s_q       <= 1'b0;
            dcnt_q        <= '0;
            state_q       <= ST_HOLD;
            cnt_q         <= '0;
            cause_q       <= CAUSE_POR;
            resetn_mem_q  <= 1'b0;
            resetn_core_q <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            sync1_q       <= bus.btn_i;
            btn_s_q       <= sync1_q;
            dcnt_q        <= dcnt_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cause_q       <= cause_d;
            resetn_mem_q  <= resetn_mem_d;
            resetn_core_q <= resetn_core_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.resetn_mem  = resetn_mem_q;
    assign bus.resetn_core = resetn_core_q;
    assign bus.busy        = busy_q;
    assign bus.rst_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: table-driven vectors through a scoreboard queue,
// plus hand-written sequences for the press-during-HOLD and RESET-in-STAGGER cases.
module tb_reset_sequencer;

    // {resetn_mem, resetn_core, busy} for each state
    localparam logic [2:0] O_HOLD = 3'b001;
    localparam logic [2:0] O_STAG = 3'b101;
    localparam logic [2:0] O_RUN  = 3'b110;

    typedef struct {
        int         n;
        logic       btn;
        logic       sw;
        logic [4:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic RESET;
    reset_sequencer_if bus();

    vec_t       vecs[$];
    logic [4:0] exp_q[$];
    int         n_compared;
    int         n_mismatched;
    logic [1:0] run_cause;

    reset_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .STAGGER_CYCLES (3)
    ) dut (
        .clk  (clk),
        .RESET(RESET),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach its end, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic add_vec(input int n, input logic b, input logic s,
                           input logic [2:0] o, input logic [1:0] c, input string nm);
        vec_t v;
        v.n    = n;
        v.btn  = b;
        v.sw   = s;
        v.exp  = {o, c};
        v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string nm);
        logic [4:0] e;
        logic [4:0] act;
        n_compared++;
        act = {bus.resetn_mem, bus.resetn_core, bus.busy, bus.rst_cause};
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL %s: scoreboard empty, got %b required an expected entry", nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_mismatched++;
                $display("[TB] FAIL %s: got mem/core/busy/cause=%b required %b (t=%0t)", nm, act, e, $time);
            end
        end
    endtask

    // Called at a negedge; drives inputs, checks one edge later, returns at the next negedge.
    task automatic applyStimulus(input logic b, input logic s, input logic [2:0] o,
                                 input logic [1:0] c, input string nm);
        bus.btn_i      = b;
        bus.sw_rst_req = s;
        exp_q.push_back({o, c});
        @(posedge clk);
        #1;
        checkOutput(nm);
        @(negedge clk);
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                bus.btn_i      = vecs[i].btn;
                bus.sw_rst_req = vecs[i].sw;
                exp_q.push_back(vecs[i].exp);
                @(posedge clk);
                #1;
                checkOutput(vecs[i].name);
                @(negedge clk);
            end
        end
        vecs.delete();
    endtask

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        RESET          = 1'b1;
        bus.btn_i      = 1'b0;
        bus.sw_rst_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back({O_HOLD, 2'b00});
        checkOutput("reset_state");
        @(negedge clk);
        RESET = 1'b0;

        add_vec(7, 0, 0, O_HOLD, 2'b00, "por_hold");
        add_vec(3, 0, 0, O_STAG, 2'b00, "por_stagger");
        add_vec(3, 0, 0, O_RUN,  2'b00, "por_run");
        add_vec(5, 1, 0, O_RUN,  2'b00, "press_latency");
        add_vec(5, 1, 0, O_HOLD, 2'b01, "press_hold_held");
        add_vec(3, 0, 0, O_HOLD, 2'b01, "press_hold");
        add_vec(3, 0, 0, O_STAG, 2'b01, "press_stagger");
        add_vec(4, 0, 0, O_RUN,  2'b01, "press_single");
        add_vec(3, 1, 0, O_RUN,  2'b01, "bounce_a");
        add_vec(1, 0, 0, O_RUN,  2'b01, "bounce_gap");
        add_vec(3, 1, 0, O_RUN,  2'b01, "bounce_b");
        add_vec(4, 0, 0, O_RUN,  2'b01, "bounce_after");
`ifdef SWRST_EN
        add_vec(1, 0, 1, O_HOLD, 2'b10, "sw_req");
        add_vec(7, 0, 0, O_HOLD, 2'b10, "sw_hold");
        add_vec(3, 0, 0, O_STAG, 2'b10, "sw_stagger");
        add_vec(2, 0, 0, O_RUN,  2'b10, "sw_run");
        run_cause = 2'b10;
`else
        add_vec(1, 0, 1, O_RUN,  2'b01, "sw_req_ignored");
        add_vec(12, 0, 0, O_RUN, 2'b01, "sw_no_effect");
        run_cause = 2'b01;
`endif
        run_table();

        // Press during HOLD: second event lands while cnt == 5 and restarts the hold count.
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, O_RUN, run_cause, "hold_press1");
        applyStimulus(0, 0, O_HOLD, 2'b01, "hold_entry");
        for (int k = 0; k < 6; k++) applyStimulus(1, 0, O_HOLD, 2'b01, "hold_press2");
        for (int k = 0; k < 7; k++) applyStimulus(0, 0, O_HOLD, 2'b01, "hold_restarted");
        applyStimulus(0, 0, O_STAG, 2'b01, "hold_release");

        // RESET asserted mid-cycle in STAGGER takes effect without a clock edge.
        #2;
        RESET = 1'b1;
        #1;
        exp_q.push_back({O_HOLD, 2'b00});
        checkOutput("async_reset_stagger");
        @(negedge clk);
        applyStimulus(0, 0, O_HOLD, 2'b00, "reset_held");
        RESET = 1'b0;

        add_vec(7, 0, 0, O_HOLD, 2'b00, "rerun_hold");
        add_vec(3, 0, 0, O_STAG, 2'b00, "rerun_stagger");
        add_vec(2, 0, 0, O_RUN,  2'b00, "rerun_run");
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset controller that follows the clock divider in the SoC. It runs on the divided system clock and generates the staggered, synchronously released active-low resets for the memory subsystem and the RISC-V core. Reset sources are power-on/system reset, a debounced board reset button, and an optional software reset request. The controller records the cause of the most recent reset.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: number of consecutive synchronized-high button samples that count as a press. Must be ≥1.
- HOLD_CYCLES, default 8: cycles both resets stay asserted after entering HOLD. Must be ≥1.
- STAGGER_CYCLES, default 3: cycles between memory release and core release. Must be ≥1.

Ports:
- clk, input, 1: divided system clock; the only clock.
- RESET, input, 1: asynchronous, active-high system/power-on reset.
- btn_i, input, 1: raw reset button; asynchronous and bouncy, active-high.
- sw_rst_req, input, 1: single-cycle software reset request from the core.
- resetn_mem, output, 1: active-low memory/peripheral reset.
- resetn_core, output, 1: active-low core reset.
- busy, output, 1: high whenever the FSM is not in RUN.
- rst_cause, output, 2: cause of the last reset. 00 = POR, 01 = button, 10 = software.

## Operation
- **Button synchronizer.** btn_i passes through a 2-FF synchronizer to give btn_s. Both flops reset to 0.
- **Debounce counter.** dcnt clears whenever btn_s = 0. It increments while btn_s = 1 and saturates at DEBOUNCE_CYCLES.
  - btn_ev pulses for exactly one cycle, when dcnt reaches DEBOUNCE_CYCLES.
  - A press produces one event however long it is held. Re-arming requires btn_s to go low.
- **FSM states:**
  - HOLD: resetn_mem = 0, resetn_core = 0.
  - STAGGER: resetn_mem = 1, resetn_core = 0.
  - RUN: both resets = 1.
- **Sequence counter.** Shared counter cnt, width $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1). It clears on every state entry.
- **Transitions:**
  - HOLD→STAGGER when cnt == HOLD_CYCLES-1.
  - STAGGER→RUN when cnt == STAGGER_CYCLES-1.
  - RUN→HOLD on btn_ev, or on sw_rst_req (if compiled in).
- **Events outside RUN:**
  - btn_ev in HOLD or STAGGER: go to HOLD, clear cnt, set rst_cause = 01.
  - sw_rst_req outside RUN: ignored.
- **Simultaneous btn_ev and sw_rst_req in RUN:** the button wins; rst_cause = 01.
- **rst_cause** updates only on entry to HOLD and holds its value otherwise.
- **Output registers.** resetn_mem, resetn_core and busy are registered state decodes. They never glitch.

## Timing
- **Asynchronous reset.** RESET high immediately forces:
  - state = HOLD, cnt = 0, dcnt = 0, synchronizer = 0;
  - resetn_mem = 0, resetn_core = 0, busy = 1, rst_cause = 00.
- **Reset release.** Deassertion of RESET is asynchronous. Counting begins at the first rising edge after RESET falls (edge 1).
- **POR release timing:**
  - resetn_mem rises at edge HOLD_CYCLES.
  - resetn_core falls-to-rises (i.e. deasserts) and busy falls at edge HOLD_CYCLES+STAGGER_CYCLES.
- **Button latency.** Count from edge 1, the first edge that samples btn_i = 1 with a stable press:
  - btn_s is high after edge 2;
  - btn_ev is high in the cycle after edge 1+DEBOUNCE_CYCLES;
  - both resets fall at edge 2+DEBOUNCE_CYCLES.
- **Software latency.** sw_rst_req high at edge n in RUN: both resets are low after edge n.
- **RESET mid-operation** in any state aborts the sequence at once. Cause becomes 00.
- **Bounce.** Button pulses of fewer than DEBOUNCE_CYCLES synchronized cycles have no effect.

## Configuration
- **SWRST_EN defined:** sw_rst_req is honored in RUN as described above.
- **SWRST_EN undefined:**
  - the port remains but is ignored;
  - cause 10 is never produced;
  - only RESET and the button can reset.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 8, STAGGER_CYCLES = 3.
- **POR.** Drop RESET before edge 1 → resetn_mem = 1 at edge 8; resetn_core = 1 and busy = 0 at edge 11; rst_cause = 00.
- **Clean press.** In RUN, btn_i high for 10 cycles from edge k → both resets low at edge k+5 (edge 1 of the press = k-1+1), rst_cause = 01. Then resetn_mem rises 8 edges later and resetn_core 3 edges after that. Exactly one reset occurs.
- **Bounce rejection.** btn_i high for 3 cycles, low for 1, high for 3 → no reset; busy stays 0.
- **Software request.** With SWRST_EN: 1-cycle sw_rst_req in RUN → resets low next edge, rst_cause = 10, full 8+3 sequence follows. Without SWRST_EN: no change.
- **Press during HOLD.** btn_ev at cnt = 5 → cnt restarts; resetn_mem rises 8 edges after the event.
- **RESET in STAGGER.** Assert RESET with resetn_mem = 1 → resetn_mem = 0 immediately, rst_cause = 00; the sequence restarts after release.
